blit_request_arbiter: RTL and testbench

// - Shares the single sprite/tile copy engine (frame-buffer write port) among NUM_REQ drawing clients
//   (tile, bomb, player, HP drawers) so they can request blits independently of the main game FSM.
// - Round-robin grant; latches the winner's x/y/memory_select/black; pulses blit_start; waits for finished.
// - Returns a per-requester done pulse.

---
 rtl/blit_request_arbiter.sv | 158 +++++++++++++++
 tb/tb_blit_request_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blit_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : blit_request_arbiter
// Brief    : Round-robin arbiter that shares the single sprite/tile copy
//            engine among NUM_REQ drawing clients. Latches the winner's
//            coordinates, select and black-fill flag, pulses blit_start,
//            waits for finished and returns a per-client done pulse.
// Options  : BLIT_TIMEOUT_EN - when defined, a BUSY watchdog aborts a blit
//            after TIMEOUT_CYCLES and sets the sticky timeout_err flag.
// Revision : 1.0 - initial release
// ============================================================================
module blit_request_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int XW             = 8,
  parameter int YW             = 7,
  parameter int SELW           = 2,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*XW-1:0]   req_x,
  input  logic [NUM_REQ*YW-1:0]   req_y,
  input  logic [NUM_REQ*SELW-1:0] req_sel,
  input  logic [NUM_REQ-1:0]      req_black,
  input  logic                    finished,
  output logic [NUM_REQ-1:0]      grant,
  output logic [NUM_REQ-1:0]      done,
  output logic                    blit_start,
  output logic [XW-1:0]           blit_x,
  output logic [YW-1:0]           blit_y,
  output logic [SELW-1:0]         memory_select,
  output logic                    black,
  output logic                    copy_enable,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int c_IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] c_ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  logic [c_IW-1:0] r_rr_ptr;
  logic [c_IW-1:0] r_winner;

  logic [c_IW-1:0] w_winner;
  logic [c_IW-1:0] w_cand;
  logic            w_found;
  logic            w_end_blit;

`ifdef BLIT_TIMEOUT_EN
  localparam int c_CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CW-1:0] c_TMAX = c_CW'(TIMEOUT_CYCLES - 1);
  logic [c_CW-1:0] r_timeout_cnt;
  logic            w_timeout_hit;
  assign w_timeout_hit = (r_timeout_cnt == c_TMAX);
  assign w_end_blit    = finished || w_timeout_hit;
`else
  // Without the watchdog the abort flag can never fire.
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign w_end_blit  = finished;
  assign timeout_err = 1'b0;
`endif

  // Round-robin search: first requesting client after the last winner, wrapping mod NUM_REQ.
  always_comb begin
    w_winner = r_rr_ptr;
    w_found  = 1'b0;
    w_cand   = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      w_cand = c_IW'((int'(r_rr_ptr) + off) % NUM_REQ);
      if (!w_found && req[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  // Control FSM with registered outputs; fields are captured only at grant time.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= c_IW'(NUM_REQ - 1);
      r_winner      <= '0;
      grant         <= '0;
      done          <= '0;
      blit_start    <= 1'b0;
      blit_x        <= '0;
      blit_y        <= '0;
      memory_select <= '0;
      black         <= 1'b0;
      copy_enable   <= 1'b0;
      busy          <= 1'b0;
`ifdef BLIT_TIMEOUT_EN
      r_timeout_cnt <= '0;
      timeout_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_winner      <= w_winner;
            grant         <= c_ONE_HOT0 << w_winner;
            blit_x        <= req_x[w_winner*XW +: XW];
            blit_y        <= req_y[w_winner*YW +: YW];
            memory_select <= req_sel[w_winner*SELW +: SELW];
            black         <= req_black[w_winner];
            blit_start    <= 1'b1;
            copy_enable   <= 1'b1;
            busy          <= 1'b1;
            r_state       <= S_START;
          end
        end
        S_START: begin
          blit_start <= 1'b0;
`ifdef BLIT_TIMEOUT_EN
          r_timeout_cnt <= '0;
`endif
          r_state    <= S_BUSY;
        end
        S_BUSY: begin
          if (w_end_blit) begin
            done        <= grant;
            grant       <= '0;
            copy_enable <= 1'b0;
            r_state     <= S_DONE;
          end
`ifdef BLIT_TIMEOUT_EN
          if (!finished && w_timeout_hit) begin
            timeout_err <= 1'b1;
          end
          r_timeout_cnt <= r_timeout_cnt + 1'b1;
`endif
        end
        S_DONE: begin
          // The finished client drops to lowest priority for the next round.
          done     <= '0;
          busy     <= 1'b0;
          r_rr_ptr <= r_winner;
          r_state  <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_blit_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_blit_request_arbiter
// Brief    : Scoreboard bench for blit_request_arbiter (4 clients,
//            TIMEOUT_CYCLES=16). Expected grants/fields and done pulses are
//            queued when requests are driven and popped when the DUT emits
//            blit_start or done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_blit_request_arbiter;

  typedef struct packed {
    logic [3:0] grant;
    logic [7:0] x;
    logic [6:0] y;
    logic [1:0] sel;
    logic       blk;
  } blit_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_x = '0;
  logic [27:0] req_y = '0;
  logic [7:0]  req_sel = '0;
  logic [3:0]  req_black = '0;
  logic        finished = 1'b0;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        blit_start;
  logic [7:0]  blit_x;
  logic [6:0]  blit_y;
  logic [1:0]  memory_select;
  logic        black;
  logic        copy_enable;
  logic        busy;
  logic        timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  blit_t      start_q[$];
  logic [3:0] done_q[$];
  blit_t      m_exp;
  logic [3:0] m_done_exp;

  blit_request_arbiter #(
    .NUM_REQ(4), .XW(8), .YW(7), .SELW(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .clock(clock), .reset(reset), .req(req), .req_x(req_x), .req_y(req_y),
    .req_sel(req_sel), .req_black(req_black), .finished(finished),
    .grant(grant), .done(done), .blit_start(blit_start), .blit_x(blit_x),
    .blit_y(blit_y), .memory_select(memory_select), .black(black),
    .copy_enable(copy_enable), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard side: compare every blit_start and done pulse against the queues.
  always @(negedge clock) begin
    if (!reset) begin
      if (blit_start) begin
        if (start_q.size() == 0) begin
          check("unexpected_start", 32'(grant), 32'(0));
        end else begin
          m_exp = start_q.pop_front();
          check("start_grant", 32'(grant), 32'(m_exp.grant));
          check("start_x", 32'(blit_x), 32'(m_exp.x));
          check("start_y", 32'(blit_y), 32'(m_exp.y));
          check("start_sel", 32'(memory_select), 32'(m_exp.sel));
          check("start_black", 32'(black), 32'(m_exp.blk));
          check("start_copy_en", 32'(copy_enable), 32'(1));
        end
      end
      if (done != 4'b0000) begin
        if (done_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'(0));
        end else begin
          m_done_exp = done_q.pop_front();
          check("done", 32'(done), 32'(m_done_exp));
          check("done_grant_clear", 32'(grant), 32'(0));
          check("done_copy_en", 32'(copy_enable), 32'(0));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_client(input int i, input logic [7:0] x, input logic [6:0] y,
                            input logic [1:0] s, input logic b);
    req_x[i*8 +: 8]   = x;
    req_y[i*7 +: 7]   = y;
    req_sel[i*2 +: 2] = s;
    req_black[i]      = b;
  endtask

  task automatic expect_blit(input logic [3:0] g, input logic [7:0] x, input logic [6:0] y,
                             input logic [1:0] s, input logic b, input bit with_done);
    blit_t e;
    e.grant = g; e.x = x; e.y = y; e.sel = s; e.blk = b;
    start_q.push_back(e);
    if (with_done) done_q.push_back(g);
  endtask

  task automatic wait_start();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clock);
      if (blit_start) seen = 1'b1;
    end
    if (!seen) check("wait_start_bound", 32'(0), 32'(1));
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clock);
      if (done != 4'b0000) seen = 1'b1;
    end
    if (!seen) check("wait_done_bound", 32'(0), 32'(1));
  endtask

  task automatic engine_finish(input int n);
    repeat (n) @(posedge clock);
    #1 finished = 1'b1;
    @(posedge clock);
    #1 finished = 1'b0;
  endtask

  task automatic pulse_reset();
    #1 reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int lat;
    // ---------------- reset state ----------------
    @(negedge clock);
    check("rst_grant", 32'(grant), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_copy_en", 32'(copy_enable), 32'(0));
    check("rst_start", 32'(blit_start), 32'(0));
    check("rst_timeout_err", 32'(timeout_err), 32'(0));
    tick();
    reset = 1'b0;

    // ---------------- single request ----------------
    set_client(2, 8'd40, 7'd30, 2'd3, 1'b0);
    expect_blit(4'b0100, 8'd40, 7'd30, 2'd3, 1'b0, 1'b1);
    req = 4'b0100;
    @(negedge clock);
    check("single_idle_before_edge", 32'(busy), 32'(0));
    @(negedge clock);
    check("single_grant", 32'(grant), 32'(4'b0100));
    check("single_start", 32'(blit_start), 32'(1));
    @(negedge clock);
    check("single_busy_start_low", 32'(blit_start), 32'(0));
    check("single_busy_copy_en", 32'(copy_enable), 32'(1));
    engine_finish(10);
    wait_done();
    tick();
    req = 4'b0000;
    @(negedge clock);
    check("single_after_grant", 32'(grant), 32'(0));
    check("single_after_done", 32'(done), 32'(0));
    check("single_after_busy", 32'(busy), 32'(0));

    // ---------------- fairness ----------------
    pulse_reset();
    for (int i = 0; i < 4; i++) set_client(i, 8'(10 + i), 7'(20 + i), 2'(i), 1'(i));
    expect_blit(4'b0001, 8'd10, 7'd20, 2'd0, 1'b0, 1'b1);
    expect_blit(4'b0010, 8'd11, 7'd21, 2'd1, 1'b1, 1'b1);
    expect_blit(4'b0100, 8'd12, 7'd22, 2'd2, 1'b0, 1'b1);
    expect_blit(4'b1000, 8'd13, 7'd23, 2'd3, 1'b1, 1'b1);
    expect_blit(4'b0001, 8'd10, 7'd20, 2'd0, 1'b0, 1'b1);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_start();
      engine_finish(3);
      wait_done();
    end
    tick();
    req = 4'b0000;

    // ---------------- field latching ----------------
    set_client(0, 8'd40, 7'd5, 2'd1, 1'b0);
    expect_blit(4'b0001, 8'd40, 7'd5, 2'd1, 1'b0, 1'b1);
    req = 4'b0001;
    wait_start();
    tick();
    req_x[7:0] = 8'd99;
    req_black[0] = 1'b1;
    @(negedge clock);
    check("latch_x_busy", 32'(blit_x), 32'(40));
    check("latch_black_busy", 32'(black), 32'(0));
    engine_finish(4);
    wait_done();
    check("latch_x_done", 32'(blit_x), 32'(40));
    tick();
    req = 4'b0000;

    // ---------------- spurious finished in IDLE ----------------
    repeat (2) tick();
    finished = 1'b1;
    tick();
    finished = 1'b0;
    repeat (2) @(negedge clock);
    check("spurious_busy", 32'(busy), 32'(0));
    check("spurious_done", 32'(done), 32'(0));
    check("spurious_grant", 32'(grant), 32'(0));

    // ---------------- reset mid-BUSY ----------------
    set_client(1, 8'd77, 7'd66, 2'd2, 1'b1);
    expect_blit(4'b0010, 8'd77, 7'd66, 2'd2, 1'b1, 1'b0);
    req = 4'b0010;
    wait_start();
    tick();
    #2 reset = 1'b1;
    #1;
    check("midrst_grant", 32'(grant), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_copy_en", 32'(copy_enable), 32'(0));
    check("midrst_blit_x", 32'(blit_x), 32'(0));
    check("midrst_done", 32'(done), 32'(0));
    tick();
    reset = 1'b0;
    set_client(0, 8'd7, 7'd8, 2'd3, 1'b0);
    set_client(3, 8'd9, 7'd1, 2'd0, 1'b1);
    expect_blit(4'b0001, 8'd7, 7'd8, 2'd3, 1'b0, 1'b1);
    req = 4'b1001;
    wait_start();
    engine_finish(2);
    wait_done();
    tick();
    req = 4'b0000;

    // ---------------- timeout ----------------
    set_client(2, 8'd3, 7'd4, 2'd1, 1'b0);
    expect_blit(4'b0100, 8'd3, 7'd4, 2'd1, 1'b0, 1'b0);
    req = 4'b0100;
    wait_start();
`ifdef BLIT_TIMEOUT_EN
    done_q.push_back(4'b0100);
    lat = 0;
    for (int i = 1; i <= 60 && lat == 0; i++) begin
      @(negedge clock);
      if (done != 4'b0000) lat = i;
    end
    check("timeout_latency", 32'(lat), 32'(17));
    check("timeout_err_set", 32'(timeout_err), 32'(1));
    tick();
    req = 4'b0000;
    repeat (5) tick();
    check("timeout_err_sticky", 32'(timeout_err), 32'(1));
    check("timeout_idle", 32'(busy), 32'(0));
`else
    lat = 0;
    repeat (100) @(negedge clock);
    check("notimeout_busy", 32'(busy), 32'(1));
    check("notimeout_copy_en", 32'(copy_enable), 32'(1));
    check("notimeout_err", 32'(timeout_err), 32'(0));
    check("notimeout_grant", 32'(grant), 32'(4'b0100));
    req = 4'b0000;
    pulse_reset();
`endif

    repeat (2) tick();
    check("start_q_empty", 32'(start_q.size()), 32'(0));
    check("done_q_empty", 32'(done_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
